// File: rtl/dbg_pkg.sv
// dbg_pkg: command codes, decoder state encoding and frame-shape helpers shared by the debug UART front end.
// S_RX_CSUM exists only when UART_DBG_CSUM_EN is defined.
package dbg_pkg;
    localparam logic [3:0] FN_STATUS      = 4'h5;
    localparam logic [3:0] FN_MEM_RD_BYTE = 4'h6;
    localparam logic [3:0] FN_MEM_RD_WORD = 4'h7;
    localparam logic [3:0] FN_REG_RD      = 4'h8;
    localparam logic [3:0] FN_BR_PT_ADD   = 4'h9;
    localparam logic [3:0] FN_BR_PT_RM    = 4'hA;
    localparam logic [3:0] FN_MEM_WR_BYTE = 4'hB;
    localparam logic [3:0] FN_MEM_WR_WORD = 4'hC;
    localparam logic [3:0] FN_REG_WR      = 4'hD;

    localparam logic [7:0] ACK_DEFAULT = 8'hA5;
    localparam logic [7:0] ERR_DEFAULT = 8'hEE;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RX_ADDR,
        S_RX_DATA,
`ifdef UART_DBG_CSUM_EN
        S_RX_CSUM,
`endif
        S_ISSUE,
        S_WAIT,
        S_TX,
        S_TX_GAP,
        S_TX_WAIT
    } state_t;

    function automatic logic is_valid(input logic [3:0] c);
        return c != 4'h0 && c <= FN_REG_WR;
    endfunction

    function automatic logic is_read(input logic [3:0] c);
        return c inside {FN_STATUS, FN_MEM_RD_BYTE, FN_MEM_RD_WORD, FN_REG_RD};
    endfunction

    function automatic logic [3:0] n_arg_bytes(input logic [3:0] c);
        return c inside {FN_MEM_WR_BYTE, FN_MEM_WR_WORD, FN_REG_WR} ? 4'd8 :
               c inside {FN_MEM_RD_BYTE, FN_MEM_RD_WORD, FN_REG_RD, FN_BR_PT_ADD, FN_BR_PT_RM} ? 4'd4 : 4'd0;
    endfunction
endpackage

// File: rtl/uart_cmd_decoder_if.sv
// uart_cmd_decoder_if: UART byte streams plus the controller command handshake seen by the decoder.
interface uart_cmd_decoder_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic [3:0]  cmd;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic        out_valid;
    logic        ctrlr_busy;
    logic [31:0] mcu_rd_data;
    logic        dec_busy;

    modport master (
        input  rx_data, rx_valid, tx_busy, ctrlr_busy, mcu_rd_data,
        output tx_data, tx_start, cmd, addr, wr_data, out_valid, dec_busy
    );
    modport slave (
        output rx_data, rx_valid, tx_busy, ctrlr_busy, mcu_rd_data,
        input  tx_data, tx_start, cmd, addr, wr_data, out_valid, dec_busy
    );
endinterface

// File: rtl/dbg_tx_serializer.sv
// dbg_tx_serializer: sends a 1- or 4-byte reply MSB first, pacing each byte against tx_busy.
module dbg_tx_serializer
    import dbg_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        four,
    input  logic [31:0] data,
    input  logic        tx_busy,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    output logic        done
);
    state_t state, state_n;
    logic [31:0] sh;
    logic [2:0] left;
    logic fire;

    assign fire = state == S_TX && !tx_busy;

    always_comb begin
        state_n = state;
        done = 1'b0;
        case (state)
            S_IDLE:    state_n = load ? S_TX : S_IDLE;
            S_TX:      state_n = tx_busy ? S_TX : S_TX_GAP;
            S_TX_GAP:  state_n = S_TX_WAIT;
            S_TX_WAIT: begin
                if (!tx_busy) begin
                    state_n = left == 3'd1 ? S_IDLE : S_TX;
                    done = left == 3'd1;
                end
            end
            default:   state_n = S_IDLE;
        endcase
    end

    // tx_start is registered, so tx_busy first shows up in S_TX_WAIT; S_TX_GAP covers that latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            sh <= '0;
            left <= '0;
            tx_data <= '0;
            tx_start <= 1'b0;
        end else begin
            state <= state_n;
            tx_start <= fire;
            if (fire) tx_data <= sh[31:24];
            if (state == S_IDLE && load) begin
                sh <= data;
                left <= four ? 3'd4 : 3'd1;
            end else if (state == S_TX_WAIT && !tx_busy) begin
                sh <= {sh[23:0], 8'h00};
                left <= left - 3'd1;
            end
        end
    end
endmodule

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: assembles host command frames from UART RX, issues them to the debug controller and replies on UART TX.
// Defining UART_DBG_CSUM_EN adds a trailing XOR checksum byte to every frame.
module uart_cmd_decoder
    import dbg_pkg::*;
#(
    parameter int unsigned RX_TIMEOUT = 1000000,
    parameter logic [7:0]  ACK_BYTE   = ACK_DEFAULT,
    parameter logic [7:0]  ERR_BYTE   = ERR_DEFAULT
) (
    input logic clk,
    input logic rst,
    uart_cmd_decoder_if.master bus
);
    state_t state, state_n, args_done;
    logic [3:0] cmd_r;
    logic [31:0] addr_r, wr_r, to_cnt;
    logic [1:0] byte_cnt;
    logic rx_state, tmo, last, bad, ld, ld_four, done;
    logic [31:0] ld_data;
`ifdef UART_DBG_CSUM_EN
    logic [7:0] csum;
    assign args_done = S_RX_CSUM;
    assign rx_state = state inside {S_RX_ADDR, S_RX_DATA, S_RX_CSUM};
`else
    assign args_done = S_ISSUE;
    assign rx_state = state inside {S_RX_ADDR, S_RX_DATA};
`endif

    assign tmo = rx_state && to_cnt == RX_TIMEOUT;
    assign last = byte_cnt == 2'd3;
    assign bad = bus.rx_data[7:4] != 4'h0 || !is_valid(bus.rx_data[3:0]);

    always_comb begin
        state_n = state;
        ld = 1'b0;
        ld_four = 1'b0;
        ld_data = {ACK_BYTE, 24'h0};
        case (state)
            S_IDLE: begin
                if (bus.rx_valid) begin
                    state_n = bad ? S_TX : n_arg_bytes(bus.rx_data[3:0]) != 4'd0 ? S_RX_ADDR : args_done;
                    ld = bad;
                    ld_data = {ERR_BYTE, 24'h0};
                end
            end
            S_RX_ADDR: state_n = tmo ? S_IDLE : (bus.rx_valid && last) ? (n_arg_bytes(cmd_r) == 4'd8 ? S_RX_DATA : args_done) : state;
            S_RX_DATA: state_n = tmo ? S_IDLE : (bus.rx_valid && last) ? args_done : state;
`ifdef UART_DBG_CSUM_EN
            S_RX_CSUM: begin
                if (tmo) state_n = S_IDLE;
                else if (bus.rx_valid) begin
                    state_n = bus.rx_data == csum ? S_ISSUE : S_TX;
                    ld = bus.rx_data != csum;
                    ld_data = {ERR_BYTE, 24'h0};
                end
            end
`endif
            S_ISSUE: state_n = S_WAIT;
            S_WAIT: begin
                if (!bus.ctrlr_busy) begin
                    state_n = S_TX;
                    ld = 1'b1;
                    ld_four = is_read(cmd_r);
                    ld_data = is_read(cmd_r) ? bus.mcu_rd_data : {ACK_BYTE, 24'h0};
                end
            end
            S_TX: state_n = done ? S_IDLE : S_TX;
            default: state_n = S_IDLE;
        endcase
    end

    // any byte arriving while a command is in flight is simply never looked at
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cmd_r <= '0;
            addr_r <= '0;
            wr_r <= '0;
            to_cnt <= '0;
            byte_cnt <= '0;
        end else begin
            state <= state_n;
            to_cnt <= (bus.rx_valid || !rx_state || tmo) ? 32'd0 : to_cnt + 32'd1;
            byte_cnt <= state == S_IDLE ? 2'd0 : (rx_state && bus.rx_valid && !tmo) ? byte_cnt + 2'd1 : byte_cnt;
            if (state == S_IDLE && bus.rx_valid) cmd_r <= bus.rx_data[3:0];
            if (state == S_RX_ADDR && bus.rx_valid && !tmo) addr_r <= {addr_r[23:0], bus.rx_data};
            if (state == S_RX_DATA && bus.rx_valid && !tmo) wr_r <= {wr_r[23:0], bus.rx_data};
        end
    end

`ifdef UART_DBG_CSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) csum <= '0;
        else if (state == S_IDLE && bus.rx_valid) csum <= bus.rx_data;
        else if (state inside {S_RX_ADDR, S_RX_DATA} && bus.rx_valid && !tmo) csum <= csum ^ bus.rx_data;
    end
`endif

    dbg_tx_serializer u_ser (
        .clk(clk),
        .rst(rst),
        .load(ld),
        .four(ld_four),
        .data(ld_data),
        .tx_busy(bus.tx_busy),
        .tx_data(bus.tx_data),
        .tx_start(bus.tx_start),
        .done(done)
    );

    assign bus.cmd = cmd_r;
    assign bus.addr = addr_r;
    assign bus.wr_data = wr_r;
    assign bus.out_valid = state == S_ISSUE;
    assign bus.dec_busy = state != S_IDLE;
endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb_uart_cmd_decoder: directed frames against uart_cmd_decoder with simple UART TX and controller responders.
// Honours UART_DBG_CSUM_EN by appending checksums and running the checksum cases.
module tb_uart_cmd_decoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    uart_cmd_decoder_if bus();

    uart_cmd_decoder #(.RX_TIMEOUT(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int busy_len = 0;
    int tx_left = 0;
    int ov_cnt = 0;
    int ov_cyc = 0;
    int tx_cyc = 0;
    logic [3:0] ov_cmd, held_cmd;
    logic [31:0] ov_addr, ov_wr, held_addr, held_wr;
    logic [7:0] txq[$];
    logic [7:0] fq[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // UART TX: busy for 5 cycles after each tx_start
    always @(posedge clk) begin
        #1;
        if (bus.tx_start) tx_left = 5;
        else if (tx_left > 0) tx_left--;
        bus.tx_busy = tx_left != 0;
    end

    always @(negedge clk) begin
        if (bus.tx_start) begin
            if (txq.size() == 0) tx_cyc = cyc;
            txq.push_back(bus.tx_data);
        end
    end

    // controller: latch the command on in_valid, then stay busy for busy_len cycles
    always @(negedge clk) begin
        if (bus.out_valid) begin
            ov_cnt++;
            ov_cyc = cyc;
            ov_cmd = bus.cmd;
            ov_addr = bus.addr;
            ov_wr = bus.wr_data;
            if (busy_len > 0) begin
                @(posedge clk);
                #1 bus.ctrlr_busy = 1'b1;
                repeat (busy_len) @(posedge clk);
                held_cmd = bus.cmd;
                held_addr = bus.addr;
                held_wr = bus.wr_data;
                #1 bus.ctrlr_busy = 1'b0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_frame();
        logic [7:0] x = 8'h00;
        foreach (fq[i]) begin
            x ^= fq[i];
            send_byte(fq[i]);
        end
`ifdef UART_DBG_CSUM_EN
        send_byte(x);
`endif
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!bus.dec_busy) break;
        end
        check("idle", {31'b0, bus.dec_busy}, 32'd0);
    endtask

    task automatic expect_tx(input string tag, input logic [31:0] w, input int n);
        check({tag, "_n"}, txq.size(), n);
        for (int i = 0; i < n && i < txq.size(); i++)
            check(tag, {24'h0, txq[i]}, n == 1 ? {24'h0, w[7:0]} : {24'h0, w[31 - 8 * i -: 8]});
        txq.delete();
    endtask

    initial begin
        bus.rx_data = 8'h00;
        bus.rx_valid = 1'b0;
        bus.tx_busy = 1'b0;
        bus.ctrlr_busy = 1'b0;
        bus.mcu_rd_data = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_cmd", {28'h0, bus.cmd}, 32'h0);
        check("rst_addr", bus.addr, 32'h0);
        check("rst_wr", bus.wr_data, 32'h0);
        check("rst_outs", {27'h0, bus.out_valid, bus.tx_start, bus.dec_busy, 1'b0, |bus.tx_data}, 32'h0);
        rst = 1'b0;

        // memory word read, controller busy 3 cycles
        bus.mcu_rd_data = 32'hDEADBEEF;
        busy_len = 3;
        fq = {8'h07, 8'h00, 8'h00, 8'h10, 8'h00};
        send_frame();
        wait_idle();
        check("rd_ov", ov_cnt, 1);
        check("rd_cmd", {28'h0, ov_cmd}, 32'h7);
        check("rd_addr", ov_addr, 32'h00001000);
        expect_tx("rd_tx", 32'hDEADBEEF, 4);

        // memory word write, fields held while busy
        fq = {8'h0C, 8'h00, 8'h00, 8'h00, 8'h20, 8'h12, 8'h34, 8'h56, 8'h78};
        send_frame();
        wait_idle();
        check("wr_ov", ov_cnt, 2);
        check("wr_cmd", {28'h0, held_cmd}, 32'hC);
        check("wr_addr", held_addr, 32'h20);
        check("wr_data", held_wr, 32'h12345678);
        expect_tx("wr_tx", 32'hA5, 1);

        // breakpoint add, controller never busy: one S_WAIT cycle
        busy_len = 0;
        fq = {8'h09, 8'h00, 8'h00, 8'h00, 8'h40};
        send_frame();
        wait_idle();
        check("bp_ov", ov_cnt, 3);
        check("bp_addr", ov_addr, 32'h40);
        check("bp_lat", tx_cyc - ov_cyc, 3);
        expect_tx("bp_tx", 32'hA5, 1);

        // malformed frames
        send_byte(8'h3F);
        wait_idle();
        expect_tx("err_hi", 32'hEE, 1);
        send_byte(8'h0E);
        wait_idle();
        expect_tx("err_e", 32'hEE, 1);
        check("err_ov", ov_cnt, 3);

        // partial frame times out with no reply
        send_byte(8'h06);
        send_byte(8'h00);
        repeat (10) @(negedge clk);
        check("to_busy", {31'b0, bus.dec_busy}, 32'd1);
        repeat (10) @(negedge clk);
        check("to_idle", {31'b0, bus.dec_busy}, 32'd0);
        check("to_tx_n", txq.size(), 0);
        check("to_ov", ov_cnt, 3);
        fq = {8'h01};
        send_frame();
        wait_idle();
        check("after_to_ov", ov_cnt, 4);
        check("after_to_cmd", {28'h0, ov_cmd}, 32'h1);
        expect_tx("after_to_tx", 32'hA5, 1);

        // stray byte during S_WAIT is dropped
        busy_len = 6;
        bus.mcu_rd_data = 32'h01020304;
        fq = {8'h08, 8'h00, 8'h00, 8'h00, 8'h03};
        send_frame();
        repeat (2) @(negedge clk);
        check("stray_wait", {31'b0, bus.ctrlr_busy}, 32'd1);
        send_byte(8'h05);
        wait_idle();
        check("stray_ov", ov_cnt, 5);
        expect_tx("stray_tx", 32'h01020304, 4);
        busy_len = 1;
        bus.mcu_rd_data = 32'hCAFEF00D;
        fq = {8'h05};
        send_frame();
        wait_idle();
        check("status_ov", ov_cnt, 6);
        check("status_cmd", {28'h0, ov_cmd}, 32'h5);
        expect_tx("status_tx", 32'hCAFEF00D, 4);

`ifdef UART_DBG_CSUM_EN
        busy_len = 0;
        send_byte(8'h01);
        send_byte(8'h01);
        wait_idle();
        check("csum_ok_ov", ov_cnt, 7);
        expect_tx("csum_ok_tx", 32'hA5, 1);
        send_byte(8'h01);
        send_byte(8'h00);
        wait_idle();
        check("csum_bad_ov", ov_cnt, 7);
        expect_tx("csum_bad_tx", 32'hEE, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule

// File: doc/uart_cmd_decoder.md
Name: uart_cmd_decoder

Overview:
- Decodes the host's serial command frames and drives the debug controller FSM through its cmd/addr/in_valid/ctrlr_busy handshake.
- Sits between the UART RX/TX byte interfaces and controller_fsm.
- Assembles each frame from UART RX bytes, issues one command, and waits for the controller to go idle.
- Then serialises a reply onto UART TX: read data for read commands, an ack for all other commands.

Parameters:
- RX_TIMEOUT, 1000000, idle clk cycles allowed between bytes of one frame before the partial frame is discarded.
- ACK_BYTE, 8'hA5, reply byte for non-read commands.
- ERR_BYTE, 8'hEE, reply byte for a malformed or unsupported frame.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe, rx_data valid.
- tx_data  out  8  byte to transmit; held until the next tx_start.
- tx_start  out  1  one-cycle strobe; UART TX raises tx_busy on the following cycle.
- tx_busy  in  1  UART TX transmitting.
- cmd  out  4  command code to controller.
- addr  out  32  address/register index to controller.
- wr_data  out  32  write data to MCU.
- out_valid  out  1  drives controller in_valid.
- ctrlr_busy  in  1  controller busy.
- mcu_rd_data  in  32  MCU read result; valid when ctrlr_busy falls.
- dec_busy  out  1  high in every state except S_IDLE.

Behaviour:
- Reset (async, rst=1): state S_IDLE; all outputs 0; internal counters and registers 0.
- Frame format, all multi-byte fields MSB first:
  - byte0 = {4'h0, cmd}.
  - 4 addr bytes for MEM_RD_BYTE(6), MEM_RD_WORD(7), REG_RD(8), BR_PT_ADD(9), BR_PT_RM(A), MEM_WR_BYTE(B), MEM_WR_WORD(C), REG_WR(D).
  - 4 data bytes in addition for B, C, D.
  - Codes 1-5 have no argument bytes.
- Read set = {STATUS(5), 6, 7, 8}; reply is 4 bytes of captured mcu_rd_data, MSB first. All other valid codes reply with a single ACK_BYTE.
- S_IDLE:
  - On rx_valid: latch cmd.
  - Upper nibble != 0, or cmd in {0, E, F} -> S_TX with reply ERR_BYTE; nothing is issued.
  - Otherwise go to S_RX_ADDR, S_RX_DATA or S_ISSUE according to the argument count.
- S_RX_ADDR / S_RX_DATA:
  - 2-bit byte_cnt; each byte shifts in as {reg[23:0], rx_data}.
  - After the 4th byte advance: ADDR -> DATA or ISSUE; DATA -> ISSUE.
- Timeout counter:
  - Cleared on each rx_valid; increments every cycle in the RX_* states.
  - Reaching RX_TIMEOUT -> S_IDLE with no reply; cmd/addr/wr_data keep their last values.
- S_ISSUE: out_valid=1 for exactly one cycle, then S_WAIT.
- S_WAIT:
  - out_valid=0; cmd/addr/wr_data held stable, because the controller re-reads cmd while waiting.
  - First cycle with ctrlr_busy=0: capture mcu_rd_data into the reply register, then go to S_TX.
  - A command that completes with no busy cycle (breakpoint add, step while running) exits after a single S_WAIT cycle.
- S_TX:
  - When tx_busy=0: pulse tx_start with the current byte, then S_TX_GAP.
  - S_TX_GAP (1 cycle) -> S_TX_WAIT.
  - S_TX_WAIT: on tx_busy=0, decrement bytes_left; 0 -> S_IDLE, else S_TX.
- rx_valid arriving in S_ISSUE, S_WAIT, S_TX, S_TX_GAP or S_TX_WAIT is dropped. There is one frame in flight only.
- rx_valid in the same cycle the timeout fires: the byte is dropped.
- Reset mid-frame or mid-reply aborts immediately; the partial TX byte is the UART's concern.

Optional Feature:
- UART_DBG_CSUM_EN
- Defined:
  - Every frame carries a trailing byte equal to the XOR of all preceding frame bytes; it is received in S_RX_CSUM, which is also covered by the timeout.
  - On mismatch: no issue; reply ERR_BYTE.
  - On match: normal issue.
- Undefined: S_RX_CSUM does not exist and the frame ends after its last data byte.

Decomposition:
- Package dbg_pkg holds:
  - FN_* 4-bit command codes, shared with controller_fsm.
  - State enum.
  - Helper functions is_read(cmd) and n_arg_bytes(cmd).
  - ACK/ERR defaults.
- One sub-module, dbg_tx_serializer: loads 1 or 4 bytes and runs the S_TX / S_TX_GAP / S_TX_WAIT sequencing against tx_busy, returning done.

Test Plan:
- Frame 07 00 00 10 00; ctrlr_busy high 3 cycles; mcu_rd_data=32'hDEADBEEF -> out_valid pulse with cmd=7, addr=32'h00001000; TX bytes DE AD BE EF.
- Frame 0C 00 00 00 20 12 34 56 78 -> cmd=C, addr=32'h20, wr_data=32'h12345678 held until ctrlr_busy=0; TX A5.
- Frame 09 00 00 00 40 with ctrlr_busy never asserting -> single out_valid, single S_WAIT cycle, TX A5.
- Byte 0x3F, then byte 0x0E -> TX EE for each; out_valid never asserted.
- RX_TIMEOUT=16: send 06 00, then idle 16 cycles -> back to S_IDLE, no TX; next frame 01 -> out_valid with cmd=1.
- Extra byte sent during S_WAIT -> ignored; next valid frame decodes correctly. With UART_DBG_CSUM_EN: frame 01 01 -> issued; frame 01 00 -> TX EE.
